// File: rtl/e_mdu_pkg.sv
// Shared opcode and state definitions for the E-stage multiply/divide unit.
// The opcode encoding must stay in step with the decoder that drives E_MDUOp.
package e_mdu_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_arith(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_mul(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide sequencer: owns HI/LO, computes the result at issue
// and holds it in pending registers until the modelled latency has elapsed.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic        E_MDUStart,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] E_MDUOut,
    output logic        E_MDUBusy
);

    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);

    mdu_op_e          op;
    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      phi_q, phi_d, plo_q, plo_d;
    logic [31:0]      res_hi, res_lo;
    logic [63:0]      prod_s, prod_u;

    assign op = mdu_op_e'(E_MDUOp);

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Divide by zero keeps the current HI/LO so the commit leaves them untouched;
    // the lone signed overflow case is pinned explicitly rather than left to the simulator.
    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV: begin
                if (B == 32'd0) begin
                    res_hi = hi_q;
                    res_lo = lo_q;
                end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                    res_hi = 32'd0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_lo = $signed(A) / $signed(B);
                    res_hi = $signed(A) % $signed(B);
                end
            end
            MDU_DIVU: begin
                if (B != 32'd0) begin
                    res_lo = A / B;
                    res_hi = A % B;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        case (state_q)
            S_IDLE: begin
                if (E_MDUStart && is_arith(op)) begin
                    phi_d   = res_hi;
                    plo_d   = res_lo;
                    cnt_d   = is_mul(op) ? MULT_LAT : DIV_LAT;
                    state_d = S_RUN;
                end else if (op == MDU_MTHI) begin
                    hi_d = A;
                end else if (op == MDU_MTLO) begin
                    lo_d = A;
                end
            end
            S_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = phi_q;
                    lo_d    = plo_q;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    always_comb begin
        case (op)
            MDU_MFHI: E_MDUOut = hi_q;
            MDU_MFLO: E_MDUOut = lo_q;
            default:  E_MDUOut = 32'd0;
        endcase
    end

    assign E_MDUBusy = (cnt_q != '0);

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: expected HI/LO and latency are queued at issue and
// checked when busy drops; inputs change and outputs are sampled on the falling edge.
module tb_e_mdu;
    import e_mdu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  E_MDUOp;
    logic        E_MDUStart;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] E_MDUOut;
    logic        E_MDUBusy;

    exp_t        sb[$];
    int          n_vec;
    int          n_err;
    logic [31:0] rd_hi, rd_lo;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .E_MDUOp    (E_MDUOp),
        .E_MDUStart (E_MDUStart),
        .A          (A),
        .B          (B),
        .E_MDUOut   (E_MDUOut),
        .E_MDUBusy  (E_MDUBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        E_MDUOp = MDU_MFHI;
        #1 h = E_MDUOut;
        E_MDUOp = MDU_MFLO;
        #1 l = E_MDUOut;
        E_MDUOp = MDU_NONE;
        #1;
    endtask

    // Called on a falling edge; issues one arithmetic op and returns one falling edge later.
    task automatic applyStimulus(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                 input int cycles, input string tag);
        exp_t e;
        e.hi = exp_hi;
        e.lo = exp_lo;
        e.cycles = cycles;
        sb.push_back(e);
        E_MDUOp    = op;
        E_MDUStart = 1'b1;
        A          = a;
        B          = b;
        @(negedge clk);
        E_MDUOp    = MDU_NONE;
        E_MDUStart = 1'b0;
        checkOutput({tag, " busy_rise"}, {31'd0, E_MDUBusy}, 32'd1);
    endtask

    task automatic write_reg(input mdu_op_e op, input logic [31:0] a);
        E_MDUOp = op;
        A       = a;
        @(negedge clk);
        E_MDUOp = MDU_NONE;
    endtask

    // Counts falling edges with busy high (starting from the current one), then checks results.
    task automatic drain(input int pre, input string tag);
        exp_t        e;
        int          n;
        logic [31:0] h, l;
        n = pre;
        while (E_MDUBusy && n < 40) begin
            n++;
            @(negedge clk);
            E_MDUOp    = MDU_NONE;
            E_MDUStart = 1'b0;
        end
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $error("[TB] FAIL %s: observed=empty_scoreboard expected=entry", tag);
        end else begin
            e = sb.pop_front();
            checkOutput({tag, " busy_cycles"}, 32'(n), 32'(e.cycles));
            read_hilo(h, l);
            checkOutput({tag, " HI"}, h, e.hi);
            checkOutput({tag, " LO"}, l, e.lo);
        end
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b0;
        E_MDUOp    = MDU_NONE;
        E_MDUStart = 1'b0;
        A          = '0;
        B          = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        checkOutput("reset busy", {31'd0, E_MDUBusy}, 32'd0);
        checkOutput("reset out_none", E_MDUOut, 32'd0);
        read_hilo(rd_hi, rd_lo);
        checkOutput("reset HI", rd_hi, 32'd0);
        checkOutput("reset LO", rd_lo, 32'd0);

        applyStimulus(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, "mult");
        drain(0, "mult");
        applyStimulus(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 32'hFFFF_FFFA, 5, "multu");
        drain(0, "multu");
        applyStimulus(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, "div");
        drain(0, "div");
        applyStimulus(MDU_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10, "divu");
        drain(0, "divu");

        write_reg(MDU_MTHI, 32'h1234);
        read_hilo(rd_hi, rd_lo);
        checkOutput("mthi 1edge", rd_hi, 32'h1234);
        write_reg(MDU_MTLO, 32'h5678);
        read_hilo(rd_hi, rd_lo);
        checkOutput("mtlo 1edge", rd_lo, 32'h5678);
        applyStimulus(MDU_DIV, 32'd99, 32'd0, 32'h1234, 32'h5678, 10, "div0");
        read_hilo(rd_hi, rd_lo);
        checkOutput("div0 mfhi_in_run", rd_hi, 32'h1234);
        drain(0, "div0");

        // MTLO and a stray start while running must both be ignored.
        applyStimulus(MDU_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 5, "mult_inject");
        E_MDUOp = MDU_MTLO;
        A       = 32'hAAAA;
        @(negedge clk);
        checkOutput("inject busy2", {31'd0, E_MDUBusy}, 32'd1);
        E_MDUOp    = MDU_MULT;
        E_MDUStart = 1'b1;
        A          = 32'd9;
        B          = 32'd9;
        @(negedge clk);
        E_MDUOp    = MDU_NONE;
        E_MDUStart = 1'b0;
        drain(2, "mult_inject");

        // Second start lands in the very first idle cycle.
        applyStimulus(MDU_MULT, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 5, "b2b_mult");
        drain(0, "b2b_mult");
        checkOutput("b2b idle_gap", {31'd0, E_MDUBusy}, 32'd0);
        applyStimulus(MDU_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 10, "b2b_div");
        drain(0, "b2b_div");

        applyStimulus(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, "div_ovf");
        drain(0, "div_ovf");

        write_reg(MDU_MTHI, 32'hDEAD);
        write_reg(MDU_MTLO, 32'hBEEF);
        applyStimulus(MDU_DIV, 32'd50, 32'd5, 32'd0, 32'd10, 10, "div_abort");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("abort busy_async", {31'd0, E_MDUBusy}, 32'd0);
        read_hilo(rd_hi, rd_lo);
        checkOutput("abort HI", rd_hi, 32'd0);
        checkOutput("abort LO", rd_lo, 32'd0);
        void'(sb.pop_front());
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort busy_after", {31'd0, E_MDUBusy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
